corelet_ctrl: RTL and testbench
===============================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows (L0 lanes).
REQ-002 SHALL have parameter col, default 8, meaning PE columns (kernels per tile).
REQ-003 SHALL have parameter addr_bw, default 11, meaning SRAM address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to run one tile.
REQ-007 SHALL have port mode  in  1  0 = WS, 1 = OS; latched at start.
REQ-008 SHALL have port acc  in  1  SFP accumulate enable; latched at start.
REQ-009 SHALL have ports n_act  in  addr_bw  activation vector count.
REQ-010 SHALL have ports w_base, a_base, p_base  in  addr_bw  weight, activation and psum base addresses; all latched at start.
REQ-011 SHALL have port ofifo_valid  in  1  corelet OFIFO holds a full output row.
REQ-012 SHALL have port inst  out  35  registered corelet instruction word.
REQ-013 SHALL have port busy  out  1  high from the cycle after start acceptance through DONE.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL drive these inst fields: [0] kernel load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_wr, [5] ififo_rd, [6] ofifo_rd, [17:7] A_xmem, [18] WEN_xmem, [19] CEN_xmem, [30:20] A_pmem, [31] WEN_pmem, [32] CEN_pmem, [33] acc, [34] mode; CEN/WEN are active-low.
REQ-016 SHALL define the idle word as 35'h1_800C_0000: CEN/WEN bits 1, all other bits 0. This word is driven in IDLE and DONE, and in every cycle not otherwise specified.
REQ-017 SHALL implement states IDLE, WLOAD, KLOAD, KGAP, ALOAD, EXEC, DRAIN, WRITE, DONE.
REQ-018 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-019 WLOAD, col+1 cycles:
- Cycles k=0..col-1 drive CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k.
- The weight write strobe is asserted one cycle after each read, in cycles 1..col: l0_wr if mode=0, ififo_wr if mode=1.
REQ-020 KLOAD, col cycles: inst[0]=1, plus the weight read strobe (l0_rd if mode=0, ififo_rd if mode=1).
REQ-021 KGAP: row cycles of the idle word plus mode/acc bits, allowing kernel propagation.
REQ-022 ALOAD, n_act+1 cycles: xmem reads at a_base+k for k=0..n_act-1; l0_wr is delayed one cycle per read.
REQ-023 EXEC, n_act cycles: inst[1]=1 and l0_rd=1.
REQ-024 DRAIN: waits with idle strobes until ofifo_valid=1.
REQ-025 WRITE, n_act beats, one beat per cycle in which ofifo_valid=1:
- Each beat drives ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+k, inst[33]=acc.
- When ofifo_valid=0, the beat counter holds and all strobes deassert (stall).
REQ-026 After the last WRITE beat, SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-027 If n_act=0, SHALL go from KGAP directly to DONE.
REQ-028 SHALL wrap address arithmetic modulo 2^addr_bw.
REQ-029 SHALL hold inst[34]=mode and inst[33]=acc constant during busy; during WRITE, inst[33] follows REQ-025.

Reset
REQ-030 With reset high at a clock edge, the next cycle SHALL have state=IDLE, inst=35'h1_800C_0000, busy=0, done=0, all counters 0, and latched parameters 0.
REQ-031 Reset mid-operation SHALL abort the tile with no further strobes; reset SHALL take priority over a simultaneous start.

Structure
REQ-032 A shared package corelet_pkg SHALL hold:
- the inst bit-index constants,
- the idle-word constant,
- the state enumeration.
REQ-033 A single sub-module ctrl_counter (load, enable, terminal-count flag, addr_bw wide) SHALL provide the beat and address counters.

Verification
REQ-034 Reset check: hold reset 2 cycles mid-EXEC -> inst=35'h1_800C_0000, busy=0 next cycle, no further strobes.
REQ-035 WS tile: mode=0, n_act=4, w_base=0, a_base=8, p_base=16, ofifo_valid=1 -> expected sequence:
- A_xmem 0..7, then l0_wr in 8 cycles, each one cycle later.
- 8 cycles of inst[0]&l0_rd, then 8 gap cycles.
- A_xmem 8..11, then 4 EXEC cycles.
- A_pmem 16..19 with ofifo_rd, then done.
REQ-036 OS weights: mode=1 -> ififo_wr/ififo_rd asserted where l0_wr/l0_rd were; l0 strobes 0 during WLOAD/KLOAD; inst[34]=1 throughout.
REQ-037 Stall: drop ofifo_valid for 3 cycles after WRITE beat 1 -> no pmem/ofifo strobes for 3 cycles; A_pmem resumes at p_base+2; done 3 cycles later than unstalled.
REQ-038 Edge cases:
- n_act=0 -> done after KGAP with zero EXEC cycles.
- p_base=2046, n_act=4 -> A_pmem 2046, 2047, 0, 1.
- start while busy -> ignored.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared corelet instruction layout, idle word and sequencer state codes.
package corelet_pkg;

  localparam int INST_W       = 35;
  localparam int ADDR_FIELD_W = 11;

  localparam int B_KLOAD    = 0;
  localparam int B_EXEC     = 1;
  localparam int B_L0_WR    = 2;
  localparam int B_L0_RD    = 3;
  localparam int B_IFIFO_WR = 4;
  localparam int B_IFIFO_RD = 5;
  localparam int B_OFIFO_RD = 6;
  localparam int B_AX_LSB   = 7;
  localparam int B_WEN_X    = 18;
  localparam int B_CEN_X    = 19;
  localparam int B_AP_LSB   = 20;
  localparam int B_WEN_P    = 31;
  localparam int B_CEN_P    = 32;
  localparam int B_ACC      = 33;
  localparam int B_MODE     = 34;

  // Memory enables/write-enables are active-low, so idle parks them high.
  localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

  typedef logic [3:0] state_t;
  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_WLOAD = 4'd1;
  localparam state_t S_KLOAD = 4'd2;
  localparam state_t S_KGAP  = 4'd3;
  localparam state_t S_ALOAD = 4'd4;
  localparam state_t S_EXEC  = 4'd5;
  localparam state_t S_DRAIN = 4'd6;
  localparam state_t S_WRITE = 4'd7;
  localparam state_t S_DONE  = 4'd8;

endpackage

// File: rtl/ctrl_counter.sv
// Loadable up-counter with terminal-count flag; exposes its next value so a
// registered decode downstream lines up with the counter's own register.
module ctrl_counter #(
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [addr_bw-1:0] load_val,
  input  logic [addr_bw-1:0] last,
  output logic [addr_bw-1:0] count_nxt,
  output logic               tc
);

  logic [addr_bw-1:0] count;

  always_comb begin
    count_nxt = count;
    if (load)    count_nxt = load_val;
    else if (en) count_nxt = count + addr_bw'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  assign tc = (count == last);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet tile sequencer: weight load, kernel load, gap, activation load, execute, drain, psum write.
// inst is registered from next-state decode; a WRITE beat issues the cycle after ofifo_valid is seen high.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               acc,
  input  logic [addr_bw-1:0] n_act,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic               accept;
  logic               mode_q, acc_q, mode_n, acc_n;
  logic [addr_bw-1:0] n_act_q, w_base_q, a_base_q, p_base_q;
  logic [addr_bw-1:0] n_act_n, w_base_n, a_base_n, p_base_n;
  logic               beat_load, beat_en, beat_tc;
  logic [addr_bw-1:0] beat_last, beat_nxt;
  logic               addr_load, addr_en, addr_tc;
  logic [addr_bw-1:0] addr_load_val, addr_last, addr_nxt;
  logic               beat_issue;
  logic [INST_W-1:0]  inst_d;

  assign accept = (state == S_IDLE) && start;

  // Tile parameters are live on the accepting edge so the first decode sees them.
  assign mode_n   = accept ? mode   : mode_q;
  assign acc_n    = accept ? acc    : acc_q;
  assign n_act_n  = accept ? n_act  : n_act_q;
  assign w_base_n = accept ? w_base : w_base_q;
  assign a_base_n = accept ? a_base : a_base_q;
  assign p_base_n = accept ? p_base : p_base_q;

  always_comb begin
    beat_last = '0;
    case (state)
      S_WLOAD: beat_last = addr_bw'(col);
      S_KLOAD: beat_last = addr_bw'(col - 1);
      S_KGAP:  beat_last = addr_bw'(row - 1);
      S_ALOAD: beat_last = n_act_n;
      S_EXEC:  beat_last = n_act_n - addr_bw'(1);
      default: beat_last = '0;
    endcase
  end

  // Write addresses never revisit within one tile, so reaching the last one ends WRITE.
  assign addr_last = p_base_n + n_act_n - addr_bw'(1);

  ctrl_counter #(.addr_bw(addr_bw)) u_beat (
    .clk(clk), .reset(reset), .load(beat_load), .en(beat_en),
    .load_val('0), .last(beat_last), .count_nxt(beat_nxt), .tc(beat_tc)
  );

  ctrl_counter #(.addr_bw(addr_bw)) u_addr (
    .clk(clk), .reset(reset), .load(addr_load), .en(addr_en),
    .load_val(addr_load_val), .last(addr_last), .count_nxt(addr_nxt), .tc(addr_tc)
  );

  always_comb begin
    state_nxt     = state;
    beat_load     = 1'b0;
    beat_en       = 1'b0;
    addr_load     = 1'b0;
    addr_en       = 1'b0;
    addr_load_val = w_base_n;
    beat_issue    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_WLOAD; beat_load = 1'b1; addr_load = 1'b1;
      end
      S_WLOAD: if (beat_tc) begin
        state_nxt = S_KLOAD; beat_load = 1'b1;
      end else begin
        beat_en = 1'b1; addr_en = 1'b1;
      end
      S_KLOAD: if (beat_tc) begin
        state_nxt = S_KGAP; beat_load = 1'b1;
      end else beat_en = 1'b1;
      S_KGAP: if (beat_tc) begin
        beat_load = 1'b1;
        if (n_act_n == '0) state_nxt = S_DONE;
        else begin
          state_nxt = S_ALOAD; addr_load = 1'b1; addr_load_val = a_base_n;
        end
      end else beat_en = 1'b1;
      S_ALOAD: if (beat_tc) begin
        state_nxt = S_EXEC; beat_load = 1'b1;
      end else begin
        beat_en = 1'b1; addr_en = 1'b1;
      end
      S_EXEC: if (beat_tc) begin
        state_nxt = S_DRAIN; beat_load = 1'b1;
      end else beat_en = 1'b1;
      S_DRAIN: if (ofifo_valid) begin
        state_nxt = S_WRITE; addr_load = 1'b1; addr_load_val = p_base_n; beat_issue = 1'b1;
      end
      S_WRITE: if (addr_tc) state_nxt = S_DONE;
      else if (ofifo_valid) begin
        addr_en = 1'b1; beat_issue = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d = IDLE_WORD;
    if (state_nxt != S_IDLE && state_nxt != S_DONE) begin
      inst_d[B_MODE] = mode_n;
      inst_d[B_ACC]  = acc_n;
    end
    case (state_nxt)
      S_WLOAD: begin
        if (beat_nxt < addr_bw'(col)) begin
          inst_d[B_CEN_X] = 1'b0;
          inst_d[B_WEN_X] = 1'b1;
          inst_d[B_AX_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(addr_nxt);
        end
        // Weight lands one cycle after its xmem read.
        if (beat_nxt != '0) inst_d[mode_n ? B_IFIFO_WR : B_L0_WR] = 1'b1;
      end
      S_KLOAD: begin
        inst_d[B_KLOAD] = 1'b1;
        inst_d[mode_n ? B_IFIFO_RD : B_L0_RD] = 1'b1;
      end
      S_ALOAD: begin
        if (beat_nxt < n_act_n) begin
          inst_d[B_CEN_X] = 1'b0;
          inst_d[B_WEN_X] = 1'b1;
          inst_d[B_AX_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(addr_nxt);
        end
        if (beat_nxt != '0) inst_d[B_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_EXEC]  = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
      end
      S_WRITE: if (beat_issue) begin
        inst_d[B_OFIFO_RD] = 1'b1;
        inst_d[B_CEN_P]    = 1'b0;
        inst_d[B_WEN_P]    = 1'b0;
        inst_d[B_AP_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(addr_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      inst     <= IDLE_WORD;
      mode_q   <= 1'b0;
      acc_q    <= 1'b0;
      n_act_q  <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
    end else begin
      state    <= state_nxt;
      inst     <= inst_d;
      mode_q   <= mode_n;
      acc_q    <= acc_n;
      n_act_q  <= n_act_n;
      w_base_q <= w_base_n;
      a_base_q <= a_base_n;
      p_base_q <= p_base_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: directed tiles plus randomized tiles against a queue-based schedule model.
module tb_corelet_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int MAXC = 600;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
  localparam logic [34:0] KEEP   = {2'b00, {33{1'b1}}};
  localparam int KL_B = 0, EX_B = 1, LWR_B = 2, LRD_B = 3, IWR_B = 4, IRD_B = 5, ORD_B = 6;
  localparam int AX_L = 7, CENX_B = 19, AP_L = 20, WENP_B = 31, CENP_B = 32, ACC_B = 33, MODE_B = 34;

  logic        clk = 1'b0;
  logic        reset, start, mode, acc, ofifo_valid;
  logic [10:0] n_act, w_base, a_base, p_base;
  logic [34:0] inst;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  bit vld [MAXC];

  always #5 clk = ~clk;

  corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .acc(acc),
    .n_act(n_act), .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    mode   = 1'($urandom);
    acc    = 1'($urandom);
    n_act  = 11'($urandom);
    w_base = 11'($urandom);
    a_base = 11'($urandom);
    p_base = 11'($urandom);
  endtask

  // vkind: 0 valid always high, 1 random valid, 2 valid low for 3 cycles once beat 1 is out.
  task automatic run_tile(input logic m, input logic a, input logic [10:0] n,
                          input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                          input int vkind, output int done_at);
    logic [34:0] q[$];
    logic [34:0] w, bw;
    int beats, plen;
    bw = IDLE_W; bw[MODE_B] = m; bw[ACC_B] = a;
    for (int k = 0; k <= COL; k++) begin
      w = bw;
      if (k < COL) begin w[CENX_B] = 1'b0; w[AX_L +: 11] = 11'(wb + k); end
      if (k > 0) w[m ? IWR_B : LWR_B] = 1'b1;
      q.push_back(w);
    end
    for (int k = 0; k < COL; k++) begin
      w = bw; w[KL_B] = 1'b1; w[m ? IRD_B : LRD_B] = 1'b1; q.push_back(w);
    end
    for (int k = 0; k < ROW; k++) q.push_back(bw);
    if (n != 0) begin
      for (int k = 0; k <= int'(n); k++) begin
        w = bw;
        if (k < int'(n)) begin w[CENX_B] = 1'b0; w[AX_L +: 11] = 11'(ab + k); end
        if (k > 0) w[LWR_B] = 1'b1;
        q.push_back(w);
      end
      for (int k = 0; k < int'(n); k++) begin
        w = bw; w[EX_B] = 1'b1; w[LRD_B] = 1'b1; q.push_back(w);
      end
      q.push_back(bw);
    end
    plen = q.size();
    for (int c = 0; c < MAXC; c++) vld[c] = (vkind == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (vkind == 2) for (int c = plen + 2; c < plen + 5; c++) vld[c] = 1'b0;

    start = 1'b1; mode = m; acc = a; n_act = n; w_base = wb; a_base = ab; p_base = pb;
    ofifo_valid = vld[0];
    beats = 0; done_at = 0;
    for (int c = 1; c < MAXC && done_at == 0; c++) begin
      @(posedge clk); #1;
      w = bw;
      if (c <= plen) w = q[c-1];
      else if (beats == int'(n)) done_at = c;
      else if (vld[c-1]) begin
        w[ORD_B] = 1'b1; w[CENP_B] = 1'b0; w[WENP_B] = 1'b0;
        w[AP_L +: 11] = 11'(pb + beats);
        beats++;
      end
      if (done_at != 0) begin
        chk($sformatf("done_inst@%0d", c), inst & KEEP, IDLE_W & KEEP);
        chk($sformatf("done_pulse@%0d", c), {34'b0, done}, 35'd1);
        chk($sformatf("done_busy@%0d", c), {34'b0, busy}, 35'd1);
      end else begin
        chk($sformatf("inst@%0d", c), inst, w);
        chk($sformatf("busy@%0d", c), {34'b0, busy}, 35'd1);
        chk($sformatf("done_low@%0d", c), {34'b0, done}, 35'd0);
      end
      scramble();
      start = (done_at == 0) && ($urandom_range(0, 3) == 0);
      ofifo_valid = vld[c];
    end
    chk("done_seen", {34'b0, done_at != 0}, 35'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_inst", inst, IDLE_W);
    chk("post_busy", {34'b0, busy}, 35'd0);
    chk("post_done", {34'b0, done}, 35'd0);
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0; mode = 1'b0; acc = 1'b0; ofifo_valid = 1'b0;
    n_act = '0; w_base = '0; a_base = '0; p_base = '0;
    @(posedge clk); #1;
    chk("rst_inst", inst, IDLE_W);
    chk("rst_busy", {34'b0, busy}, 35'd0);
    chk("rst_done", {34'b0, done}, 35'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_tile(1'b0, 1'b0, 11'd4, 11'd0, 11'd8, 11'd16, 0, d);
    chk("ws_done_cycle", 35'(d), 35'd40);
    run_tile(1'b1, 1'b1, 11'd4, 11'd100, 11'd200, 11'd300, 0, d);
    chk("os_done_cycle", 35'(d), 35'd40);
    run_tile(1'b0, 1'b0, 11'd4, 11'd0, 11'd8, 11'd16, 2, d);
    chk("stall_done_cycle", 35'(d), 35'd43);
    run_tile(1'b0, 1'b1, 11'd0, 11'd5, 11'd6, 11'd7, 0, d);
    chk("nact0_done_cycle", 35'(d), 35'd26);
    run_tile(1'b0, 1'b0, 11'd4, 11'd2045, 11'd2047, 11'd2046, 0, d);

    // Abort mid-EXEC with a 2-cycle reset.
    start = 1'b1; mode = 1'b0; acc = 1'b0; n_act = 11'd4;
    w_base = 11'd0; a_base = 11'd8; p_base = 11'd16; ofifo_valid = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk); #1;
      if (c == 31) chk("exec_word", inst, IDLE_W | 35'hA);
      if (c >= 33) begin
        chk($sformatf("abort_inst@%0d", c), inst, IDLE_W);
        chk($sformatf("abort_busy@%0d", c), {34'b0, busy}, 35'd0);
        chk($sformatf("abort_done@%0d", c), {34'b0, done}, 35'd0);
      end
      start = 1'b0;
      reset = (c == 32 || c == 33);
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_start_busy", {34'b0, busy}, 35'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start_inst", inst, IDLE_W);
    chk("rst_vs_start_busy2", {34'b0, busy}, 35'd0);

    for (int t = 0; t < 16; t++) begin
      run_tile(1'($urandom), 1'($urandom), 11'($urandom_range(0, 6)),
               11'($urandom), 11'($urandom), 11'($urandom_range(2040, 2047)), 1, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
